// File: rtl/power_req_ctrl.sv
// Purpose: generates L1_module_req for the PSO state machine, tracks L1 status, wake and done.
// Latency: trigger or exit condition to L1_module_req change is 1 cycle; all outputs registered.
// Backpressure: none; set/clr status handshakes are level inputs sampled once per cycle.
module power_req_ctrl #(
    parameter int IDLE_CNT_W  = 16,
    parameter int HOLDOFF_CYC = 4
) (
    input  logic                  pclk,
    input  logic                  nprst,
    input  logic                  sw_pso_req,
    input  logic                  auto_pso_en,
    input  logic [IDLE_CNT_W-1:0] idle_thresh,
    input  logic                  module_busy,
    input  logic                  wake_event,
    input  logic                  set_status_module,
    input  logic                  clr_status_module,
    output logic                  L1_module_req,
    output logic                  L1_status,
    output logic                  wake_pending,
    output logic                  pso_done_irq,
    output logic [IDLE_CNT_W-1:0] idle_cnt
);

    typedef enum logic [2:0] {
        ST_ACTIVE  = 3'd0,
        ST_REQ     = 3'd1,
        ST_DOWN    = 3'd2,
        ST_WAKE    = 3'd3,
        ST_HOLDOFF = 3'd4
    } state_t;

    localparam logic [IDLE_CNT_W-1:0] IDLE_MAX  = {IDLE_CNT_W{1'b1}};
    localparam logic [IDLE_CNT_W-1:0] IDLE_ONE  = {{(IDLE_CNT_W-1){1'b0}}, 1'b1};
    // Holdoff counts down to zero, so load one less than the cycle count.
    localparam logic [7:0]            HOLD_LAST = 8'(HOLDOFF_CYC - 1);

    state_t     state;
    logic       sw_pso_req_q;
    logic       src_sw;
    logic [7:0] hold_cnt;
    logic       sw_rise;
    logic       auto_hit;
    logic       idle_run;
    logic       down_exit;

    assign sw_rise   = sw_pso_req & ~sw_pso_req_q;
    assign auto_hit  = auto_pso_en & (idle_thresh != '0) & (idle_cnt >= idle_thresh);
    assign idle_run  = (state == ST_ACTIVE) & auto_pso_en & ~module_busy & ~wake_event;
    // Leave shut-off when woken, when the owning request source goes away.
    assign down_exit = wake_event | (src_sw & ~sw_pso_req) | (~src_sw & ~auto_pso_en);

    // Software request edge detector: previous level of sw_pso_req.
    always_ff @(posedge pclk or negedge nprst) begin
        if (!nprst) begin
            sw_pso_req_q <= 1'b0;
        end else begin
            sw_pso_req_q <= sw_pso_req;
        end
    end

    // Idle counter: counts quiet ACTIVE cycles with auto enabled, saturates, else clears.
    always_ff @(posedge pclk or negedge nprst) begin
        if (!nprst) begin
            idle_cnt <= '0;
        end else if (idle_run) begin
            if (idle_cnt != IDLE_MAX) begin
                idle_cnt <= idle_cnt + IDLE_ONE;
            end
        end else begin
            idle_cnt <= '0;
        end
    end

    // PSO request FSM with registered request, status, wake-pending and done pulse.
    always_ff @(posedge pclk or negedge nprst) begin
        if (!nprst) begin
            state         <= ST_ACTIVE;
            L1_module_req <= 1'b0;
            L1_status     <= 1'b0;
            wake_pending  <= 1'b0;
            pso_done_irq  <= 1'b0;
            src_sw        <= 1'b0;
            hold_cnt      <= 8'd0;
        end else begin
            pso_done_irq <= 1'b0;
            case (state)
                ST_ACTIVE: begin
                    L1_module_req <= 1'b0;
                    // Blocked software edges are dropped, not remembered.
                    if (!wake_event && !module_busy && (sw_rise || auto_hit)) begin
                        state         <= ST_REQ;
                        L1_module_req <= 1'b1;
                        src_sw        <= sw_rise;
                    end
                end
                ST_REQ: begin
                    // Shut-off already started wins over a wake in the same cycle.
                    if (set_status_module) begin
                        state     <= ST_DOWN;
                        L1_status <= 1'b1;
                        if (wake_event) begin
                            wake_pending <= 1'b1;
                        end
                    end else if (wake_event) begin
                        state         <= ST_ACTIVE;
                        L1_module_req <= 1'b0;
                    end
                end
                ST_DOWN: begin
                    if (wake_event) begin
                        wake_pending <= 1'b1;
                    end
                    // Dropping req here is safe: the PSO machine finishes shut-off first.
                    if (down_exit) begin
                        state         <= ST_WAKE;
                        L1_module_req <= 1'b0;
                    end
                end
                ST_WAKE: begin
                    if (clr_status_module) begin
                        state        <= ST_HOLDOFF;
                        L1_status    <= 1'b0;
                        pso_done_irq <= 1'b1;
                        wake_pending <= 1'b0;
                        hold_cnt     <= HOLD_LAST;
                    end else if (wake_event) begin
                        wake_pending <= 1'b1;
                    end
                end
                ST_HOLDOFF: begin
                    // Keep req low long enough that a new request cannot chase the last cycle.
                    if (hold_cnt == 8'd0) begin
                        state <= ST_ACTIVE;
                    end else begin
                        hold_cnt <= hold_cnt - 8'd1;
                    end
                end
                default: begin
                    state         <= ST_ACTIVE;
                    L1_module_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_power_req_ctrl.sv
// Purpose: self-checking bench for power_req_ctrl against a cycle-level behavioural model.
// Latency: model advances once per clock, outputs compared every falling edge.
// Backpressure: n/a; PSO state machine responses are driven as random or directed stimulus.
module tb_power_req_ctrl;

    localparam int W        = 16;
    localparam int HOLD     = 4;
    localparam int IDLE_TOP = 65535;

    logic          pclk;
    logic          nprst;
    logic          sw_pso_req;
    logic          auto_pso_en;
    logic [W-1:0]  idle_thresh;
    logic          module_busy;
    logic          wake_event;
    logic          set_status_module;
    logic          clr_status_module;
    logic          L1_module_req;
    logic          L1_status;
    logic          wake_pending;
    logic          pso_done_irq;
    logic [W-1:0]  idle_cnt;

    int checks = 0;
    int errors = 0;

    power_req_ctrl #(
        .IDLE_CNT_W (W),
        .HOLDOFF_CYC(HOLD)
    ) dut (
        .pclk             (pclk),
        .nprst            (nprst),
        .sw_pso_req       (sw_pso_req),
        .auto_pso_en      (auto_pso_en),
        .idle_thresh      (idle_thresh),
        .module_busy      (module_busy),
        .wake_event       (wake_event),
        .set_status_module(set_status_module),
        .clr_status_module(clr_status_module),
        .L1_module_req    (L1_module_req),
        .L1_status        (L1_status),
        .wake_pending     (wake_pending),
        .pso_done_irq     (pso_done_irq),
        .idle_cnt         (idle_cnt)
    );

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Phases of the PSO cycle as seen from outside.
    localparam int P_ACT = 0, P_REQ = 1, P_DOWN = 2, P_WAKE = 3, P_HOLD = 4;
    int m_ph, m_cnt, m_hold;
    bit m_req, m_stat, m_wp, m_irq, m_src, m_swq;

    always @(posedge pclk or negedge nprst) begin
        if (!nprst) begin
            m_ph = P_ACT; m_cnt = 0; m_hold = 0;
            m_req = 0; m_stat = 0; m_wp = 0; m_irq = 0; m_src = 0; m_swq = 0;
        end else begin
            bit rise, hit;
            int n_cnt;
            rise = sw_pso_req && !m_swq;
            hit  = auto_pso_en && (idle_thresh != 0) && (m_cnt >= int'(idle_thresh));
            if (m_ph == P_ACT && auto_pso_en && !module_busy && !wake_event)
                n_cnt = (m_cnt + 1 > IDLE_TOP) ? IDLE_TOP : m_cnt + 1;
            else
                n_cnt = 0;
            m_irq = 0;
            case (m_ph)
                P_ACT: if (!wake_event && !module_busy && (rise || hit)) begin
                    m_ph = P_REQ; m_req = 1; m_src = rise;
                end
                P_REQ: if (set_status_module) begin
                    m_ph = P_DOWN; m_stat = 1;
                    if (wake_event) m_wp = 1;
                end else if (wake_event) begin
                    m_ph = P_ACT; m_req = 0;
                end
                P_DOWN: begin
                    if (wake_event) m_wp = 1;
                    if (wake_event || (m_src ? !sw_pso_req : !auto_pso_en)) begin
                        m_ph = P_WAKE; m_req = 0;
                    end
                end
                P_WAKE: if (clr_status_module) begin
                    m_ph = P_HOLD; m_stat = 0; m_irq = 1; m_wp = 0; m_hold = HOLD;
                end else if (wake_event) m_wp = 1;
                default: begin
                    m_hold = m_hold - 1;
                    if (m_hold == 0) m_ph = P_ACT;
                end
            endcase
            m_swq = sw_pso_req;
            m_cnt = n_cnt;
        end
    end

    // Compare every output against the model on each falling edge.
    always @(negedge pclk) begin
        chk("cmp_req",  32'(L1_module_req), 32'(m_req));
        chk("cmp_stat", 32'(L1_status),     32'(m_stat));
        chk("cmp_wp",   32'(wake_pending),  32'(m_wp));
        chk("cmp_irq",  32'(pso_done_irq),  32'(m_irq));
        chk("cmp_idle", 32'(idle_cnt),      32'(m_cnt));
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic run_auto(input int busy_at, input int exp_edges, input string name);
        int n;
        auto_pso_en = 1'b0;
        step();
        idle_thresh = 16'd10;
        auto_pso_en = 1'b1;
        n = 0;
        while (n < 40) begin
            n++;
            module_busy = (n == busy_at);
            step();
            if (L1_module_req) break;
        end
        chk(name, 32'(n), 32'(exp_edges));
        module_busy = 1'b0;
        auto_pso_en = 1'b0;
        wake_event  = 1'b1;
        step();
        wake_event  = 1'b0;
        chk({name, "_abort"}, 32'(L1_module_req), 32'd0);
    endtask

    initial begin
        int n;
        nprst = 1'b0;
        sw_pso_req = 1'b0; auto_pso_en = 1'b0; idle_thresh = '0; module_busy = 1'b0;
        wake_event = 1'b0; set_status_module = 1'b0; clr_status_module = 1'b0;
        repeat (3) step();
        chk("rst_req",  32'(L1_module_req), 32'd0);
        chk("rst_stat", 32'(L1_status),     32'd0);
        chk("rst_wp",   32'(wake_pending),  32'd0);
        chk("rst_irq",  32'(pso_done_irq),  32'd0);
        chk("rst_idle", 32'(idle_cnt),      32'd0);
        nprst = 1'b1;
        step();

        // Software-initiated cycle.
        sw_pso_req = 1'b1;
        step();
        chk("sw_req_rise", 32'(L1_module_req), 32'd1);
        set_status_module = 1'b1;
        step();
        set_status_module = 1'b0;
        chk("sw_stat_set", 32'(L1_status), 32'd1);
        chk("sw_req_held", 32'(L1_module_req), 32'd1);
        sw_pso_req = 1'b0;
        step();
        chk("sw_drop_req", 32'(L1_module_req), 32'd0);
        step();
        clr_status_module = 1'b1;
        step();
        clr_status_module = 1'b0;
        chk("done_irq", 32'(pso_done_irq), 32'd1);
        chk("done_stat", 32'(L1_status), 32'd0);
        sw_pso_req = 1'b1;
        step();
        chk("irq_single", 32'(pso_done_irq), 32'd0);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("no_retrigger", 32'(L1_module_req), 32'd0);
        end
        sw_pso_req = 1'b0;
        step();

        // Idle-based automatic request, plain and with a busy pulse.
        run_auto(-1, 11, "auto_11");
        run_auto(6, 17, "auto_busy");

        // Abort in REQ without set_status.
        sw_pso_req = 1'b1;
        step();
        wake_event = 1'b1;
        step();
        wake_event = 1'b0;
        chk("abort_req", 32'(L1_module_req), 32'd0);
        chk("abort_stat", 32'(L1_status), 32'd0);
        chk("abort_wp", 32'(wake_pending), 32'd0);
        sw_pso_req = 1'b0;
        step();

        // Wake and set_status together in REQ: shut-off proceeds, wake remembered.
        sw_pso_req = 1'b1;
        step();
        wake_event = 1'b1;
        set_status_module = 1'b1;
        step();
        wake_event = 1'b0;
        set_status_module = 1'b0;
        chk("setwake_stat", 32'(L1_status), 32'd1);
        chk("setwake_wp", 32'(wake_pending), 32'd1);
        chk("setwake_req", 32'(L1_module_req), 32'd1);
        sw_pso_req = 1'b0;
        step();
        chk("setwake_exit", 32'(L1_module_req), 32'd0);
        clr_status_module = 1'b1;
        step();
        clr_status_module = 1'b0;
        chk("setwake_wp_clr", 32'(wake_pending), 32'd0);
        repeat (5) step();

        // Auto-origin cycle woken during shut-off.
        idle_thresh = 16'd3;
        auto_pso_en = 1'b1;
        n = 0;
        while (n < 20 && !L1_module_req) begin
            n++;
            step();
        end
        chk("wd_auto_req", 32'(L1_module_req), 32'd1);
        set_status_module = 1'b1;
        step();
        set_status_module = 1'b0;
        wake_event = 1'b1;
        step();
        wake_event = 1'b0;
        chk("wd_req_low", 32'(L1_module_req), 32'd0);
        chk("wd_wp_set", 32'(wake_pending), 32'd1);
        repeat (3) step();
        chk("wd_wp_hold", 32'(wake_pending), 32'd1);
        clr_status_module = 1'b1;
        step();
        clr_status_module = 1'b0;
        chk("wd_wp_clr", 32'(wake_pending), 32'd0);
        auto_pso_en = 1'b0;
        repeat (5) step();

        // Zero threshold never triggers; counter saturates.
        idle_thresh = '0;
        auto_pso_en = 1'b1;
        repeat (IDLE_TOP + 5) step();
        chk("sat_idle", 32'(idle_cnt), 32'h0000_FFFF);
        chk("sat_noreq", 32'(L1_module_req), 32'd0);
        step();
        chk("sat_nowrap", 32'(idle_cnt), 32'h0000_FFFF);
        auto_pso_en = 1'b0;
        step();

        // Asynchronous reset in the middle of shut-off.
        sw_pso_req = 1'b1;
        step();
        set_status_module = 1'b1;
        step();
        set_status_module = 1'b0;
        chk("down_stat", 32'(L1_status), 32'd1);
        #2;
        nprst = 1'b0;
        #1;
        chk("arst_req",  32'(L1_module_req), 32'd0);
        chk("arst_stat", 32'(L1_status),     32'd0);
        chk("arst_wp",   32'(wake_pending),  32'd0);
        chk("arst_idle", 32'(idle_cnt),      32'd0);
        sw_pso_req = 1'b0;
        @(negedge pclk);
        #2;
        nprst = 1'b1;
        step();
        sw_pso_req = 1'b1;
        step();
        chk("post_rst_req", 32'(L1_module_req), 32'd1);
        wake_event = 1'b1;
        step();
        wake_event = 1'b0;
        sw_pso_req = 1'b0;
        step();

        // Randomised traffic; set and clr never asserted together.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0)  sw_pso_req  = ~sw_pso_req;
            if ($urandom_range(0, 31) == 0) auto_pso_en = ~auto_pso_en;
            if ($urandom_range(0, 63) == 0) idle_thresh = 16'($urandom_range(0, 20));
            module_busy       = ($urandom_range(0, 4) == 0);
            wake_event        = ($urandom_range(0, 11) == 0);
            set_status_module = ($urandom_range(0, 3) == 0);
            clr_status_module = !set_status_module && ($urandom_range(0, 5) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/power_req_ctrl.md
Name: power_req_ctrl

Overview:
- Upstream request generator for the power-controller PSO state machine; drives its L1_module_req and consumes its set_status_module / clr_status_module.
- Decides when a module enters power shut-off: on a software request edge, or automatically after a programmable idle period.
- Decides when the module wakes: software clear, external wake event, or auto-mode disable.
- Holds the L1 status bit and raises a done pulse when power-up completes; enforces a hold-off so a fresh request can never chase the previous cycle.

Parameters:
- IDLE_CNT_W, 16, width of idle counter and idle_thresh
- HOLDOFF_CYC, 4, cycles L1_module_req is forced low after power-up completes (1..255)

Ports:
- pclk  input  1  clock, single domain
- nprst  input  1  asynchronous active-low reset
- sw_pso_req  input  1  software PSO request bit (level; rising edge triggers)
- auto_pso_en  input  1  enable idle-based automatic PSO
- idle_thresh  input  IDLE_CNT_W  idle cycles before auto request; 0 disables auto trigger
- module_busy  input  1  module activity; clears idle count and blocks entry
- wake_event  input  1  external wake (level or pulse)
- set_status_module  input  1  from PSO state machine: shut-off sequence started
- clr_status_module  input  1  from PSO state machine: power-up sequence finished
- L1_module_req  output  1  PSO request to state machine (registered)
- L1_status  output  1  module in PSO cycle (set..clr)
- wake_pending  output  1  wake event latched during PSO cycle
- pso_done_irq  output  1  one-cycle pulse on power-up completion
- idle_cnt  output  IDLE_CNT_W  current idle count (debug/readback)

Behaviour:
- Reset: state ACTIVE; L1_module_req, L1_status, wake_pending, pso_done_irq = 0; idle_cnt = 0; sw edge register = 0. Reset mid-cycle aborts to ACTIVE immediately.
- sw_rise = sw_pso_req & ~sw_pso_req_q (sw_pso_req_q registered every cycle).
- Idle counter:
  - In ACTIVE with auto_pso_en=1 and module_busy=0 and wake_event=0: increment, saturate at all-ones.
  - Cleared to 0 otherwise (busy, wake, auto disabled, any other state).
- auto_hit = auto_pso_en & (idle_thresh != 0) & (idle_cnt >= idle_thresh).
- States, with all outputs registered:
  - ACTIVE:
    - req=0.
    - If ~wake_event & ~module_busy & (sw_rise | auto_hit): go to REQ, req=1 from the next cycle. Record src_sw = sw_rise; sw takes priority when both are true.
    - A sw_rise that is blocked by busy or wake is lost, not queued.
  - REQ:
    - req=1. set_status_module: go to DOWN, L1_status<=1.
    - Else if wake_event: go to ACTIVE, req<=0 (abort; no status change).
    - set_status has priority over wake_event in the same cycle.
  - DOWN:
    - req=1. Exit condition: wake_event, or (src_sw & ~sw_pso_req), or (~src_sw & ~auto_pso_en).
    - On exit: go to WAKE, req<=0.
    - Dropping req early is legal: the state machine completes its shut-off and powers up on sampling req=0.
  - WAKE:
    - req=0. On clr_status_module: go to HOLDOFF; L1_status<=0, pso_done_irq=1 for one cycle, wake_pending<=0.
  - HOLDOFF:
    - req=0. Count HOLDOFF_CYC cycles, then go to ACTIVE with idle_cnt=0.
    - Inputs other than reset are ignored.
- wake_pending: set on wake_event in REQ (when not aborting), DOWN or WAKE; cleared on clr_status_module; never set in ACTIVE/HOLDOFF.
- clr_status_module outside WAKE, or set_status_module outside REQ: ignored (no state or status change).
- set and clr status in the same cycle: not legal input; behaviour unspecified.
- Latency: trigger condition -> L1_module_req high = 1 cycle; exit condition -> L1_module_req low = 1 cycle.

Test Plan:
- Software cycle: sw_pso_req 0->1, state machine returns set_status_module 1 cycle after req -> L1_status=1; deassert sw_pso_req -> req low next cycle; clr_status_module -> pso_done_irq single pulse, L1_status=0, req held 0 for 4 cycles, then sw_pso_req held high does not re-trigger.
- Auto idle: auto_pso_en=1, idle_thresh=10, module_busy=0 -> req rises exactly 11 cycles after enable; module_busy pulse at cycle 6 -> count restarts at 0, req delayed accordingly.
- Wake during DOWN: auto-origin cycle, wake_event pulse -> req low next cycle, wake_pending=1 until clr_status_module, then 0.
- Abort in REQ: wake_event in same cycle as REQ with no set_status -> back to ACTIVE, req=0, L1_status stays 0; same with set_status present -> DOWN, wake_pending=1.
- Edge/saturation: idle_thresh=0 with auto_pso_en=1 -> no request ever; idle_cnt saturates at 16'hFFFF without wrap.
- Reset mid-cycle: nprst low while in DOWN -> req, L1_status, wake_pending, idle_cnt all 0 asynchronously; after release, state is ACTIVE.
